// File: rtl/npc_ras_unit.sv
// Next-PC unit: owns the architectural PC, computes sequential/branch/jump targets,
// and keeps a circular return-address stack that checks return predictions.
module npc_ras_unit #(
    parameter int unsigned         WIDTH     = 32,
    parameter logic [WIDTH-1:0]    RESET_PC  = 32'h0000_3000,
    parameter int unsigned         OFF_BITS  = 16,
    parameter int unsigned         ABS_BITS  = 26,
    parameter int unsigned         RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_wr,
    input  logic [2:0]          npc_op,
    input  logic                br_taken,
    input  logic [OFF_BITS-1:0] imm_off,
    input  logic [ABS_BITS-1:0] imm_abs,
    input  logic [WIDTH-1:0]    pc_jr,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_plus4,
    output logic [WIDTH-1:0]    npc,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_ovf,
    output logic                ras_miss,
    output logic                align_err
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ = 3'b000,
        OP_BR  = 3'b001,
        OP_J   = 3'b010,
        OP_JR  = 3'b011,
        OP_JAL = 3'b100,
        OP_RET = 3'b101
    } npc_op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             miss_q, miss_d;
    logic             align_q, align_d;

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] raw_target;
    logic [PTR_W-1:0] ptr_dec;
    logic [WIDTH-1:0] ras_pred;
    logic             is_push;
    logic             is_pop;

    // Target generation; the raw target keeps its low bits so misalignment can be flagged.
    always_comb begin
        pc_plus4   = pc_q + WIDTH'(4);
        off_ext    = {{(WIDTH-OFF_BITS-2){imm_off[OFF_BITS-1]}}, imm_off, 2'b00};
        br_target  = pc_q + off_ext;
        j_target   = {pc_plus4[WIDTH-1:ABS_BITS+2], imm_abs, 2'b00};
        raw_target = pc_plus4;
        is_push    = 1'b0;
        is_pop     = 1'b0;
        unique case (npc_op)
            OP_BR:   raw_target = br_taken ? br_target : pc_plus4;
            OP_J:    raw_target = j_target;
            OP_JAL: begin
                raw_target = j_target;
                is_push    = 1'b1;
            end
            OP_JR:   raw_target = pc_jr;
            OP_RET: begin
                raw_target = pc_jr;
                is_pop     = 1'b1;
            end
            default: raw_target = pc_plus4;
        endcase
        npc = {raw_target[WIDTH-1:2], 2'b00};
    end

    assign ptr_dec  = ptr_q - PTR_W'(1);
    assign ras_pred = ras_mem_q[ptr_dec];

    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        miss_d  = 1'b0;
        align_d = 1'b0;
        if (pc_wr) begin
            pc_d    = npc;
            align_d = (raw_target[1:0] != 2'b00);
            if (is_push) begin
                ptr_d = ptr_q + PTR_W'(1);
                if (cnt_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (is_pop) begin
                // An empty stack cannot predict, so the return always counts as a miss.
                if (cnt_q != '0) begin
                    ptr_d  = ptr_dec;
                    cnt_d  = cnt_q - CNT_W'(1);
                    miss_d = (ras_pred != pc_jr);
                end else begin
                    miss_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            miss_q  <= 1'b0;
            align_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            miss_q  <= miss_d;
            align_q <= align_d;
        end
    end

    // Entries carry no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (pc_wr && is_push) begin
            ras_mem_q[ptr_q] <= pc_plus4;
        end
    end

    assign pc        = pc_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);
    assign ras_ovf   = ovf_q;
    assign ras_miss  = miss_q;
    assign align_err = align_q;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed bench for npc_ras_unit: a table of write steps with hand-computed
// next-PC / PC / flag expectations, then an asynchronous reset sequence.
module tb_npc_ras_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_wr = 1'b0;
    logic [2:0]  npc_op = 3'b000;
    logic        br_taken = 1'b0;
    logic [15:0] imm_off = '0;
    logic [25:0] imm_abs = '0;
    logic [31:0] pc_jr = '0;
    logic [31:0] pc, pc_plus4, npc;
    logic        ras_empty, ras_full, ras_ovf, ras_miss, align_err;

    int n_checks = 0;
    int n_fail   = 0;

    npc_ras_unit dut (
        .clk(clk), .rst(rst), .pc_wr(pc_wr), .npc_op(npc_op), .br_taken(br_taken),
        .imm_off(imm_off), .imm_abs(imm_abs), .pc_jr(pc_jr),
        .pc(pc), .pc_plus4(pc_plus4), .npc(npc),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
        .ras_miss(ras_miss), .align_err(align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        wr;
        logic        tk;
        logic [15:0] off;
        logic [25:0] abs;
        logic [31:0] jr;
        logic [31:0] e_npc;
        logic [31:0] e_pc;
        logic        e_empty, e_full, e_ovf, e_miss, e_align;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [2:0] op, input logic wr, input logic tk,
                       input logic [15:0] off, input logic [25:0] abs, input logic [31:0] jr,
                       input logic [31:0] e_npc, input logic [31:0] e_pc,
                       input logic e_empty, input logic e_full, input logic e_ovf,
                       input logic e_miss, input logic e_align);
        vq.push_back('{op, wr, tk, off, abs, jr, e_npc, e_pc,
                       e_empty, e_full, e_ovf, e_miss, e_align});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {ras_empty, ras_full, ras_ovf, ras_miss, align_err};
    endfunction

    initial begin
        //   op    wr  tk off       abs         jr            npc           pc            E F O M A
        add(3'd0, 1, 0, 16'h0000, 26'h0,      32'h0,        32'h00003004, 32'h00003004, 1,0,0,0,0);
        add(3'd0, 1, 0, 16'h0000, 26'h0,      32'h0,        32'h00003008, 32'h00003008, 1,0,0,0,0);
        add(3'd0, 1, 0, 16'h0000, 26'h0,      32'h0,        32'h0000300C, 32'h0000300C, 1,0,0,0,0);
        add(3'd0, 1, 0, 16'h0000, 26'h0,      32'h0,        32'h00003010, 32'h00003010, 1,0,0,0,0);
        add(3'd1, 1, 1, 16'hFFFC, 26'h0,      32'h0,        32'h00003000, 32'h00003000, 1,0,0,0,0);
        add(3'd2, 1, 0, 16'h0000, 26'h0C04,   32'h0,        32'h00003010, 32'h00003010, 1,0,0,0,0);
        add(3'd1, 1, 0, 16'hFFFC, 26'h0,      32'h0,        32'h00003014, 32'h00003014, 1,0,0,0,0);
        add(3'd2, 1, 0, 16'h0000, 26'h0C04,   32'h0,        32'h00003010, 32'h00003010, 1,0,0,0,0);
        add(3'd1, 1, 1, 16'h0003, 26'h0,      32'h0,        32'h0000301C, 32'h0000301C, 1,0,0,0,0);
        add(3'd2, 1, 0, 16'h0000, 26'h0C00,   32'h0,        32'h00003000, 32'h00003000, 1,0,0,0,0);
        // call/return pair with a correct prediction
        add(3'd4, 1, 0, 16'h0000, 26'h0C10,   32'h0,        32'h00003040, 32'h00003040, 0,0,0,0,0);
        add(3'd5, 1, 0, 16'h0000, 26'h0,      32'h00003004, 32'h00003004, 32'h00003004, 1,0,0,0,0);
        // misaligned register jump, then a held cycle clears the pulse
        add(3'd3, 1, 0, 16'h0000, 26'h0,      32'h00003006, 32'h00003004, 32'h00003004, 1,0,0,0,1);
        add(3'd0, 0, 0, 16'h0000, 26'h0,      32'h0,        32'h00003008, 32'h00003004, 1,0,0,0,0);
        add(3'd6, 1, 0, 16'h0000, 26'h0,      32'h0,        32'h00003008, 32'h00003008, 1,0,0,0,0);
        add(3'd5, 1, 0, 16'h0000, 26'h0,      32'h00003000, 32'h00003000, 32'h00003000, 1,0,0,1,0);
        add(3'd0, 0, 0, 16'h0000, 26'h0,      32'h0,        32'h00003004, 32'h00003000, 1,0,0,0,0);
        // upper PC bits survive J; large negative branch wraps the region
        add(3'd3, 1, 0, 16'h0000, 26'h0,      32'h80000000, 32'h80000000, 32'h80000000, 1,0,0,0,0);
        add(3'd2, 1, 0, 16'h0000, 26'h0000001,32'h0,        32'h80000004, 32'h80000004, 1,0,0,0,0);
        add(3'd1, 1, 1, 16'h8000, 26'h0,      32'h0,        32'h7FFE0004, 32'h7FFE0004, 1,0,0,0,0);
        add(3'd3, 1, 0, 16'h0000, 26'h0,      32'h00003000, 32'h00003000, 32'h00003000, 1,0,0,0,0);
        // five calls overflow the four-entry stack
        add(3'd4, 1, 0, 16'h0000, 26'h0C40,   32'h0,        32'h00003100, 32'h00003100, 0,0,0,0,0);
        add(3'd4, 1, 0, 16'h0000, 26'h0C80,   32'h0,        32'h00003200, 32'h00003200, 0,0,0,0,0);
        add(3'd4, 1, 0, 16'h0000, 26'h0CC0,   32'h0,        32'h00003300, 32'h00003300, 0,0,0,0,0);
        add(3'd4, 1, 0, 16'h0000, 26'h0D00,   32'h0,        32'h00003400, 32'h00003400, 0,1,0,0,0);
        add(3'd4, 1, 0, 16'h0000, 26'h0D40,   32'h0,        32'h00003500, 32'h00003500, 0,1,1,0,0);
        add(3'd5, 1, 0, 16'h0000, 26'h0,      32'h00003404, 32'h00003404, 32'h00003404, 0,0,1,0,0);
        add(3'd5, 1, 0, 16'h0000, 26'h0,      32'h00003304, 32'h00003304, 32'h00003304, 0,0,1,0,0);
        add(3'd5, 1, 0, 16'h0000, 26'h0,      32'h00003204, 32'h00003204, 32'h00003204, 0,0,1,0,0);
        add(3'd5, 1, 0, 16'h0000, 26'h0,      32'h00003104, 32'h00003104, 32'h00003104, 1,0,1,0,0);
        add(3'd5, 1, 0, 16'h0000, 26'h0,      32'h00003000, 32'h00003000, 32'h00003000, 1,0,1,1,0);
        add(3'd0, 0, 0, 16'h0000, 26'h0,      32'h0,        32'h00003004, 32'h00003000, 1,0,1,0,0);
        // wrong prediction, then the pulse clears on a following write
        add(3'd4, 1, 0, 16'h0000, 26'h0C10,   32'h0,        32'h00003040, 32'h00003040, 0,0,1,0,0);
        add(3'd5, 1, 0, 16'h0000, 26'h0,      32'h00003008, 32'h00003008, 32'h00003008, 1,0,1,1,0);
        add(3'd0, 1, 0, 16'h0000, 26'h0,      32'h0,        32'h0000300C, 32'h0000300C, 1,0,1,0,0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_pc", pc, 32'h00003000);
        check("reset_flags", {27'd0, flags()}, {27'd0, 5'b10000});

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            npc_op   = vq[i].op;
            pc_wr    = vq[i].wr;
            br_taken = vq[i].tk;
            imm_off  = vq[i].off;
            imm_abs  = vq[i].abs;
            pc_jr    = vq[i].jr;
            #1;
            check($sformatf("step%0d_npc", i), npc, vq[i].e_npc);
            @(posedge clk);
            #1;
            check($sformatf("step%0d_pc", i), pc, vq[i].e_pc);
            check($sformatf("step%0d_flags", i), {27'd0, flags()},
                  {27'd0, vq[i].e_empty, vq[i].e_full, vq[i].e_ovf, vq[i].e_miss, vq[i].e_align});
            $display("step %0d op=%0d wr=%0d pc=0x%08h flags=%05b", i, vq[i].op, vq[i].wr, pc, flags());
        end

        // Asynchronous reset between edges after two calls (ovf is still set from above).
        @(negedge clk);
        npc_op = 3'd4; pc_wr = 1'b1; imm_abs = 26'h0C40;
        @(posedge clk); #1;
        check("arst_pre_jal1_pc", pc, 32'h00003100);
        @(negedge clk);
        imm_abs = 26'h0C80;
        @(posedge clk); #1;
        check("arst_pre_jal2_pc", pc, 32'h00003200);
        check("arst_pre_empty", {31'd0, ras_empty}, 32'd0);
        @(negedge clk);
        pc_wr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h00003000);
        check("arst_flags", {27'd0, flags()}, {27'd0, 5'b10000});
        $display("async reset applied pc=0x%08h flags=%05b", pc, flags());
        @(negedge clk);
        rst = 1'b0;
        npc_op = 3'd0; pc_wr = 1'b1;
        @(posedge clk); #1;
        check("post_arst_seq_pc", pc, 32'h00003004);
        check("post_arst_pcp4", pc_plus4, 32'h00003008);
        pc_wr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
